dmb_readout_sched: RTL and testbench



---
 rtl/dmb_readout_sched_pkg.sv | 17 +
 rtl/dmb_readout_sched_live_ch_count.sv | 28 ++
 rtl/dmb_readout_sched.sv | 197 +++++++++++++++++++
 tb/tb_dmb_readout_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmb_readout_sched_pkg.sv
// Shared constants and FSM state type for the DMB per-event readout scheduler.
package dmb_readout_sched_pkg;

  localparam int unsigned DMB_NCH        = 15;
  localparam int unsigned DMB_CW         = 4;
  localparam int unsigned DMB_TMO_W      = 8;
  localparam int unsigned DMB_TMO_CYCLES = 200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COUNT  = 3'd1,
    ST_SELECT = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } sched_state_e;

endpackage

// File: rtl/dmb_readout_sched_live_ch_count.sv
// Registered popcount of the live-channel mask; result appears one clock after the mask.
module live_ch_count
  import dmb_readout_sched_pkg::*;
#(
  parameter int unsigned NCH = DMB_NCH,
  parameter int unsigned CW  = DMB_CW
) (
  input  logic           CLK,
  input  logic [NCH-1:0] MASK,
  output logic [CW-1:0]  CNT
);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d = cnt_d + CW'(MASK[i]);
    end
  end

  always_ff @(posedge CLK) begin
    cnt_q <= cnt_d;
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/dmb_readout_sched.sv
// Per-event DMB readout scheduler: grants live channels one at a time, lowest index first.
// Optional per-grant timeout enabled by defining DMB_SCHED_TIMEOUT_EN.
module dmb_readout_sched
  import dmb_readout_sched_pkg::*;
#(
  parameter int unsigned NCH = DMB_NCH,
  parameter int unsigned CW  = DMB_CW
`ifdef DMB_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TMO_W      = DMB_TMO_W,
  parameter int unsigned TMO_CYCLES = DMB_TMO_CYCLES
`endif
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           EVT_START,
  input  logic [NCH-1:0] LIVE_MASK,
  input  logic           CH_DONE,
  output logic           BUSY,
  output logic [NCH-1:0] GRANT,
  output logic [CW-1:0]  GRANT_ID,
  output logic [CW-1:0]  NCH_EXP,
  output logic [CW-1:0]  NCH_DONE,
  output logic           EVT_DONE,
  output logic           OVLP,
  output logic [NCH-1:0] TMO_MASK
);

  sched_state_e   state_q, state_d;
  logic [NCH-1:0] pend_q, pend_d, pend_left;
  logic [NCH-1:0] grant_q, grant_d;
  logic [CW-1:0]  grant_id_q, grant_id_d;
  logic [CW-1:0]  nch_exp_q, nch_exp_d;
  logic [CW-1:0]  nch_done_q, nch_done_d;
  logic           busy_q, busy_d;
  logic           evt_done_q, evt_done_d;
  logic           ovlp_q, ovlp_d;
  logic [CW-1:0]  sel_idx;
  logic           sel_found;
  logic [CW-1:0]  pop_cnt;
  logic           tmo_hit;

  // Counting pend_d means the count is valid exactly during COUNT, when NCH_EXP is loaded.
  live_ch_count #(
    .NCH (NCH),
    .CW  (CW)
  ) u_live_ch_count (
    .CLK  (CLK),
    .MASK (pend_d),
    .CNT  (pop_cnt)
  );

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pend_q[i] && !sel_found) begin
        sel_idx   = CW'(i);
        sel_found = 1'b1;
      end
    end
  end

`ifdef DMB_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [NCH-1:0]   tmo_mask_q, tmo_mask_d;

  assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_W'(TMO_CYCLES - 1));

  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_mask_d = tmo_mask_q;
    if (state_q == ST_IDLE && EVT_START) begin
      tmo_mask_d = '0;
    end
    if (state_q == ST_SELECT) begin
      tmo_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      // CH_DONE on the timeout cycle counts as a normal completion.
      if (tmo_hit && !CH_DONE) begin
        tmo_mask_d = tmo_mask_q | grant_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tmo_cnt_q  <= '0;
      tmo_mask_q <= '0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_mask_q <= tmo_mask_d;
    end
  end

  assign TMO_MASK = tmo_mask_q;
`else
  assign tmo_hit  = 1'b0;
  assign TMO_MASK = '0;
`endif

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    nch_exp_d  = nch_exp_q;
    nch_done_d = nch_done_q;
    evt_done_d = 1'b0;
    ovlp_d     = EVT_START && (state_q != ST_IDLE);
    pend_left  = pend_q & ~grant_q;

    unique case (state_q)
      ST_IDLE: begin
        if (EVT_START) begin
          pend_d     = LIVE_MASK;
          nch_done_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_COUNT;
        end
      end
      ST_COUNT: begin
        nch_exp_d = pop_cnt;
        if (pend_q == '0) begin
          state_d    = ST_FINISH;
          evt_done_d = 1'b1;
        end else begin
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        grant_d    = NCH'(1) << sel_idx;
        grant_id_d = sel_idx;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (CH_DONE || tmo_hit) begin
          pend_d  = pend_left;
          grant_d = '0;
          if (CH_DONE) begin
            nch_done_d = nch_done_q + CW'(1);
          end
          if (pend_left == '0) begin
            state_d    = ST_FINISH;
            evt_done_d = 1'b1;
          end else begin
            state_d = ST_SELECT;
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      grant_id_q <= '0;
      nch_exp_q  <= '0;
      nch_done_q <= '0;
      evt_done_q <= 1'b0;
      ovlp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      nch_exp_q  <= nch_exp_d;
      nch_done_q <= nch_done_d;
      evt_done_q <= evt_done_d;
      ovlp_q     <= ovlp_d;
    end
  end

  assign BUSY     = busy_q;
  assign GRANT    = grant_q;
  assign GRANT_ID = grant_id_q;
  assign NCH_EXP  = nch_exp_q;
  assign NCH_DONE = nch_done_q;
  assign EVT_DONE = evt_done_q;
  assign OVLP     = ovlp_q;

endmodule

// File: tb/tb_dmb_readout_sched.sv
// Randomized self-checking bench for dmb_readout_sched against a transaction-level event model.
module tb_dmb_readout_sched;

  localparam int NCH = 15;
  localparam int CW  = 4;
`ifdef DMB_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int TMO    = 4;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int TMO    = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           evt_start = 1'b0;
  logic [NCH-1:0] live_mask = '0;
  logic           ch_done = 1'b0;
  logic           busy;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  grant_id;
  logic [CW-1:0]  nch_exp;
  logic [CW-1:0]  nch_done;
  logic           evt_done;
  logic           ovlp;
  logic [NCH-1:0] tmo_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmb_readout_sched #(
    .NCH (NCH),
    .CW  (CW)
`ifdef DMB_SCHED_TIMEOUT_EN
    ,
    .TMO_W      (8),
    .TMO_CYCLES (TMO)
`endif
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .EVT_START (evt_start),
    .LIVE_MASK (live_mask),
    .CH_DONE   (ch_done),
    .BUSY      (busy),
    .GRANT     (grant),
    .GRANT_ID  (grant_id),
    .NCH_EXP   (nch_exp),
    .NCH_DONE  (nch_done),
    .EVT_DONE  (evt_done),
    .OVLP      (ovlp),
    .TMO_MASK  (tmo_mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_hold(input int forced);
    if (forced != 0) return forced;
    if (TMO_EN) return int'($urandom_range(TMO + 1, 1));
    return int'($urandom_range(4, 1));
  endfunction

  // hold_*: WAIT edge (1-based) on which CH_DONE is asserted; 0 = random, >TMO = never.
  task automatic run_event(input logic [NCH-1:0] mask, input bit all_done,
                           input int hold_first, input int hold_rest,
                           input bit ovlp_mid, input bit ovlp_at_done);
    int             exp_ch[$];
    int             idx = 0;
    int             t = 0;
    int             zero_run = 0;
    int             wait_edges = 0;
    int             hold = 0;
    int             exp_done = 0;
    logic [NCH-1:0] prev_g = '0;
    logic [NCH-1:0] exp_tmo = '0;
    bit             drove_done = 1'b0;
    bit             drove_ovlp = 1'b0;
    bit             ovlp_used = 1'b0;
    bit             finished = 1'b0;
    bit             rel;
    bit             rel_tmo;
    bit             exp_evt;

    for (int i = 0; i < NCH; i++) if (mask[i]) exp_ch.push_back(i);

    evt_start = 1'b1;
    live_mask = mask;
    ch_done   = 1'b0;
    step();
    evt_start = 1'b0;
    live_mask = NCH'($urandom);

    while (!finished && t < 500) begin
      t++;
      rel     = 1'b0;
      rel_tmo = 1'b0;
      check("ovlp", ovlp, drove_ovlp);
      check("busy", busy, 1'b1);
      if (t == 2) check("nch_exp", nch_exp, exp_ch.size());

      if (prev_g != '0) begin
        wait_edges++;
        rel_tmo = TMO_EN && !drove_done && (wait_edges == TMO);
        rel     = drove_done || rel_tmo;
        if (rel) begin
          check("grant_release", grant, '0);
          if (drove_done) exp_done++;
          else exp_tmo |= prev_g;
          zero_run = 1;
        end else begin
          check("grant_hold", grant, prev_g);
        end
      end else if (grant != '0) begin
        if (idx >= exp_ch.size()) begin
          check("grant_extra", grant, '0);
        end else begin
          check("grant", grant, 1 << exp_ch[idx]);
          check("grant_id", grant_id, exp_ch[idx]);
          if (idx == 0) check("first_grant_lat", t, 3);
          else check("grant_gap", zero_run, 1);
          hold = pick_hold(idx == 0 ? hold_first : hold_rest);
          idx++;
          wait_edges = 0;
        end
      end else begin
        zero_run++;
      end

      exp_evt = (exp_ch.size() == 0) ? (t == 2) : (rel && idx == exp_ch.size());
      check("evt_done", evt_done, exp_evt);
      if (exp_evt) begin
        check("nch_done", nch_done, exp_done);
        check("tmo_mask", tmo_mask, exp_tmo);
        check("grants_seen", idx, exp_ch.size());
        check("nch_exp_end", nch_exp, exp_ch.size());
      end
      finished = exp_evt || evt_done;

      drove_ovlp = 1'b0;
      if ((ovlp_mid && !ovlp_used && grant != '0) || (ovlp_at_done && finished)) begin
        evt_start  = 1'b1;
        live_mask  = NCH'($urandom);
        drove_ovlp = 1'b1;
        ovlp_used  = 1'b1;
      end else begin
        evt_start = 1'b0;
      end
      if (grant != '0) ch_done = all_done || (wait_edges + 1 == hold);
      else ch_done = all_done || ($urandom_range(1, 0) == 1);
      drove_done = ch_done;
      prev_g     = grant;
      step();
    end

    check("evt_finished", finished, 1'b1);
    check("ovlp_after", ovlp, drove_ovlp);
    check("busy_after", busy, 1'b0);
    check("evt_done_after", evt_done, 1'b0);
    check("nch_done_hold", nch_done, exp_done);
    evt_start = 1'b0;
    ch_done   = 1'b0;
    step();
    check("busy_idle", busy, 1'b0);
    check("ovlp_idle", ovlp, 1'b0);
  endtask

  initial begin
    int n;
    logic [NCH-1:0] m;

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, '0);
    check("rst_grant_id", grant_id, '0);
    check("rst_nch_exp", nch_exp, '0);
    check("rst_nch_done", nch_done, '0);
    check("rst_evt_done", evt_done, 1'b0);
    check("rst_ovlp", ovlp, 1'b0);
    check("rst_tmo_mask", tmo_mask, '0);

    repeat (3) begin
      ch_done = 1'b1;
      step();
      check("idle_grant", grant, '0);
      check("idle_nch_done", nch_done, '0);
      check("idle_busy", busy, 1'b0);
      ch_done = 1'b0;
      step();
    end

    run_event(15'h0005, 1'b0, 1, 1, 1'b0, 1'b0);
    run_event(15'h0000, 1'b0, 0, 0, 1'b0, 1'b0);
    run_event(15'h7FFF, 1'b1, 0, 0, 1'b0, 1'b0);
    run_event(15'h0492, 1'b0, 0, 0, 1'b1, 1'b0);
    run_event(15'h4001, 1'b0, 0, 0, 1'b0, 1'b1);
    run_event(15'h0000, 1'b0, 0, 0, 1'b0, 1'b1);
`ifdef DMB_SCHED_TIMEOUT_EN
    run_event(15'h0012, 1'b0, TMO + 1, 2, 1'b0, 1'b0);
    run_event(15'h0012, 1'b0, TMO, 1, 1'b0, 1'b0);
`endif

    evt_start = 1'b1;
    live_mask = 15'h0300;
    step();
    evt_start = 1'b0;
    n = 0;
    while (grant == '0 && n < 10) begin
      step();
      n++;
    end
    check("mid_rst_grant_pre", grant, 15'h0100);
    rst_n = 1'b0;
    step();
    check("mid_rst_grant", grant, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_evt_done", evt_done, 1'b0);
    check("mid_rst_nch_exp", nch_exp, '0);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_evt_done", evt_done, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end

    for (int k = 0; k < 25; k++) begin
      m = NCH'($urandom);
      if ($urandom_range(5, 0) == 0) m = '0;
      run_event(m, $urandom_range(4, 0) == 0, 0, 0,
                $urandom_range(2, 0) == 0, $urandom_range(3, 0) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
